// File: rtl/sdram_stream_writer.sv
// Small synchronous FIFO with registered head (no fall-through) and synchronous clear.
// Latency: a word pushed at edge M is visible at the head from cycle M+1.
// Backpressure: full/empty are flags only; the caller must not push when full or pop when empty.
module stream_fifo #(
    parameter int W  = 17,
    parameter int AW = 2
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            // Cleared storage keeps the head, and so the write data output, at zero after reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr_q] <= push_dat;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop_rdy) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_vld, pop_rdy})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr_q];
    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
endmodule

// Stream-to-SDRAM write master: buffers upstream words and writes them at base+index.
// Latency: a word accepted at edge M is on the write bus in cycle M+1; one word per clock sustained.
// Backpressure: iWAIT_REQUEST holds the bus request; oDATA_READY drops once the FIFO is full.
module sdram_stream_writer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 25,
    parameter int FIFO_AW = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iTRIGGER,
    input  logic [ADDR_W-1:0] iBASE_ADDR,
    input  logic [ADDR_W-1:0] iWORD_COUNT,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDATA_VALID,
    input  logic              iLAST,
    output logic              oDATA_READY,
    input  logic              iWAIT_REQUEST,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [DATA_W-1:0] oWR_DATA,
    output logic              oDONE,
    output logic              oABORTED,
    output logic [ADDR_W-1:0] oWORDS_WRITTEN
);
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] dat;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT, DONE_WAIT} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] acc_cnt_q;
    logic [ADDR_W-1:0] wr_idx_q;
    logic              eos_q;
    logic              aborted_q;
    logic              pend_q;

    entry_t push_dat;
    entry_t head_dat;
    logic   fifo_full, fifo_empty;
    logic   start, abort_done, in_rdy, push_vld, wr_vld, wr_fire, last_flag, done;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        abort_done = 1'b0;
        in_rdy     = 1'b0;
        wr_vld     = 1'b0;
        done       = 1'b0;
        wr_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                done = 1'b1;
                if (iTRIGGER) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                in_rdy  = !fifo_full && !eos_q;
                wr_vld  = !fifo_empty;
                wr_fire = wr_vld && !iWAIT_REQUEST;
                if (wr_fire && head_dat.last) state_d = DONE_WAIT;
                else if (!iTRIGGER)           state_d = ABORT;
            end
            ABORT: begin
                // Only a request that was already stalled on the bus is allowed to finish.
                wr_vld  = pend_q && !fifo_empty;
                wr_fire = wr_vld && !iWAIT_REQUEST;
                if (!wr_vld || wr_fire) begin
                    state_d    = IDLE;
                    abort_done = 1'b1;
                end
            end
            DONE_WAIT: begin
                done = 1'b1;
                if (!iTRIGGER) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_vld  = iDATA_VALID && in_rdy;
    assign last_flag = iLAST || ((count_q != '0) && (acc_cnt_q == count_q - ADDR_W'(1)));
    assign push_dat  = '{last: last_flag, dat: iDATA};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            base_q    <= '0;
            count_q   <= '0;
            acc_cnt_q <= '0;
            wr_idx_q  <= '0;
            eos_q     <= 1'b0;
            aborted_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            pend_q <= wr_vld && iWAIT_REQUEST;
            if (start) begin
                base_q    <= iBASE_ADDR;
                count_q   <= iWORD_COUNT;
                acc_cnt_q <= '0;
                wr_idx_q  <= '0;
                eos_q     <= 1'b0;
                aborted_q <= 1'b0;
            end else begin
                if (push_vld) begin
                    acc_cnt_q <= acc_cnt_q + ADDR_W'(1);
                    if (last_flag) eos_q <= 1'b1;
                end
                if (wr_fire)    wr_idx_q  <= wr_idx_q + ADDR_W'(1);
                if (abort_done) aborted_q <= 1'b1;
            end
        end
    end

    stream_fifo #(
        .W  ($bits(entry_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .clr      (start || abort_done),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (wr_fire),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign oDATA_READY    = in_rdy;
    assign oWR_EN         = wr_vld;
    assign oWR_ADDR       = base_q + wr_idx_q;
    assign oWR_DATA       = head_dat.dat;
    assign oDONE          = done;
    assign oABORTED       = aborted_q;
    assign oWORDS_WRITTEN = wr_idx_q;
endmodule

// File: tb/tb_sdram_stream_writer.sv
// Directed bench for sdram_stream_writer: per-cycle vector table plus hand-written corner sequences.
module tb_sdram_stream_writer;
    logic        iCLK;
    logic        iRST;
    logic        iTRIGGER;
    logic [24:0] iBASE_ADDR;
    logic [24:0] iWORD_COUNT;
    logic [15:0] iDATA;
    logic        iDATA_VALID;
    logic        iLAST;
    logic        oDATA_READY;
    logic        iWAIT_REQUEST;
    logic        oWR_EN;
    logic [24:0] oWR_ADDR;
    logic [15:0] oWR_DATA;
    logic        oDONE;
    logic        oABORTED;
    logic [24:0] oWORDS_WRITTEN;

    sdram_stream_writer #(.DATA_W(16), .ADDR_W(25), .FIFO_AW(2)) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iTRIGGER       (iTRIGGER),
        .iBASE_ADDR     (iBASE_ADDR),
        .iWORD_COUNT    (iWORD_COUNT),
        .iDATA          (iDATA),
        .iDATA_VALID    (iDATA_VALID),
        .iLAST          (iLAST),
        .oDATA_READY    (oDATA_READY),
        .iWAIT_REQUEST  (iWAIT_REQUEST),
        .oWR_EN         (oWR_EN),
        .oWR_ADDR       (oWR_ADDR),
        .oWR_DATA       (oWR_DATA),
        .oDONE          (oDONE),
        .oABORTED       (oABORTED),
        .oWORDS_WRITTEN (oWORDS_WRITTEN)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [24:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t wr_log[$];

    // Completed bus writes, sampled mid-cycle.
    always @(negedge iCLK) begin
        if (!iRST && oWR_EN && !iWAIT_REQUEST) wr_log.push_back('{oWR_ADDR, oWR_DATA});
    end

    typedef struct {
        logic        trig;
        logic        vld;
        logic [15:0] dat;
        logic        wt;
        logic        e_rdy;
        logic        e_wen;
        logic [24:0] e_addr;
        logic [15:0] e_dat;
        logic        e_done;
        logic [24:0] e_ww;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic start(input logic [24:0] base, input logic [24:0] cnt);
        iBASE_ADDR  = base;
        iWORD_COUNT = cnt;
        iTRIGGER    = 1'b1;
        tick();
    endtask

    task automatic send(input int n, input logic [15:0] d0, input bit use_last);
        int  k = 0;
        int  g = 0;
        logic hs;
        while (k < n && g < 200) begin
            iDATA_VALID = 1'b1;
            iDATA       = d0 + 16'(k);
            iLAST       = use_last && (k == n - 1);
            hs          = oDATA_READY;
            tick();
            if (hs) k++;
            g++;
        end
        iDATA_VALID = 1'b0;
        iLAST       = 1'b0;
        chk("send_accepted", k, n);
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while (!oDONE && g < 100) begin
            tick();
            g++;
        end
        chk(name, oDONE, 1'b1);
    endtask

    task automatic check_log(input string name, input int n, input logic [24:0] base, input logic [15:0] d0);
        chk({name, "_count"}, wr_log.size(), n);
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            chk({name, "_addr"}, wr_log[i].a, base + 25'(i));
            chk({name, "_data"}, wr_log[i].d, d0 + 16'(i));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_done"}, oDONE, 1'b1);
        chk({name, "_wr_en"}, oWR_EN, 1'b0);
        chk({name, "_rdy"}, oDATA_READY, 1'b0);
        chk({name, "_addr"}, oWR_ADDR, 25'h0);
        chk({name, "_data"}, oWR_DATA, 16'h0);
        chk({name, "_aborted"}, oABORTED, 1'b0);
        chk({name, "_words"}, oWORDS_WRITTEN, 25'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [24:0] wrap_exp [4];

        iRST = 1'b1; iTRIGGER = 1'b0; iBASE_ADDR = '0; iWORD_COUNT = '0;
        iDATA = '0; iDATA_VALID = 1'b0; iLAST = 1'b0; iWAIT_REQUEST = 1'b0;

        // Count mode, one row per cycle: inputs, then expected outputs in that cycle.
        vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 25'h000, 16'h0000, 1'b1, 25'd0};
        vecs[1] = '{1'b1, 1'b1, 16'hA0A0, 1'b0, 1'b1, 1'b0, 25'h000, 16'h0000, 1'b0, 25'd0};
        vecs[2] = '{1'b1, 1'b1, 16'hA0A1, 1'b0, 1'b1, 1'b1, 25'h100, 16'hA0A0, 1'b0, 25'd0};
        vecs[3] = '{1'b1, 1'b1, 16'hA0A2, 1'b0, 1'b1, 1'b1, 25'h101, 16'hA0A1, 1'b0, 25'd1};
        vecs[4] = '{1'b1, 1'b1, 16'hA0A3, 1'b0, 1'b1, 1'b1, 25'h102, 16'hA0A2, 1'b0, 25'd2};
        vecs[5] = '{1'b1, 1'b1, 16'hA0A4, 1'b0, 1'b0, 1'b1, 25'h103, 16'hA0A3, 1'b0, 25'd3};
        vecs[6] = '{1'b1, 1'b1, 16'hA0A4, 1'b0, 1'b0, 1'b0, 25'h000, 16'h0000, 1'b1, 25'd4};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 25'h000, 16'h0000, 1'b1, 25'd4};
        vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 25'h000, 16'h0000, 1'b1, 25'd4};

        #12;
        check_reset_outputs("reset");
        tick();
        iRST = 1'b0;

        iBASE_ADDR  = 25'h100;
        iWORD_COUNT = 25'd4;
        wr_log.delete();
        for (int i = 0; i < 9; i++) begin
            iTRIGGER      = vecs[i].trig;
            iDATA_VALID   = vecs[i].vld;
            iDATA         = vecs[i].dat;
            iWAIT_REQUEST = vecs[i].wt;
            @(negedge iCLK);
            chk($sformatf("vec%0d_rdy", i), oDATA_READY, vecs[i].e_rdy);
            chk($sformatf("vec%0d_wr_en", i), oWR_EN, vecs[i].e_wen);
            chk($sformatf("vec%0d_done", i), oDONE, vecs[i].e_done);
            chk($sformatf("vec%0d_words", i), oWORDS_WRITTEN, vecs[i].e_ww);
            if (vecs[i].e_wen) begin
                chk($sformatf("vec%0d_addr", i), oWR_ADDR, vecs[i].e_addr);
                chk($sformatf("vec%0d_data", i), oWR_DATA, vecs[i].e_dat);
            end
            tick();
        end
        check_log("count_log", 4, 25'h100, 16'hA0A0);

        // iLAST-terminated, unbounded count.
        wr_log.delete();
        start(25'h200, 25'd0);
        send(3, 16'hB000, 1'b1);
        wait_done("last_done");
        check_log("last_log", 3, 25'h200, 16'hB000);
        chk("last_words", oWORDS_WRITTEN, 25'd3);
        chk("last_rdy_after_eos", oDATA_READY, 1'b0);
        iTRIGGER = 1'b0;
        tick();
        chk("last_idle_done", oDONE, 1'b1);
        tick();
        chk("last_idle_done2", oDONE, 1'b1);
        chk("last_idle_rdy", oDATA_READY, 1'b0);

        // Ten-cycle stall on the second write with the source always valid.
        wr_log.delete();
        iWAIT_REQUEST = 1'b0;
        start(25'h300, 25'd8);
        fork
            send(8, 16'hC000, 1'b0);
            begin
                int g = 0;
                while (wr_log.size() < 1 && g < 50) begin
                    tick();
                    g++;
                end
                chk("stall_first_write", wr_log.size(), 1);
                iWAIT_REQUEST = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    chk("stall_wr_en", oWR_EN, 1'b1);
                    chk("stall_addr", oWR_ADDR, 25'h301);
                    chk("stall_data", oWR_DATA, 16'hC001);
                    tick();
                end
                chk("stall_rdy_full", oDATA_READY, 1'b0);
                iWAIT_REQUEST = 1'b0;
            end
        join
        wait_done("stall_done");
        check_log("stall_log", 8, 25'h300, 16'hC000);
        chk("stall_words", oWORDS_WRITTEN, 25'd8);
        iTRIGGER = 1'b0;
        tick();
        tick();

        // Address wrap at the top of the address space.
        wr_log.delete();
        start(25'h1FFFFFE, 25'd4);
        send(4, 16'hD000, 1'b0);
        wait_done("wrap_done");
        wrap_exp[0] = 25'h1FFFFFE;
        wrap_exp[1] = 25'h1FFFFFF;
        wrap_exp[2] = 25'h0000000;
        wrap_exp[3] = 25'h0000001;
        chk("wrap_count", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            chk("wrap_addr", wr_log[i].a, wrap_exp[i]);
            chk("wrap_data", wr_log[i].d, 16'hD000 + 16'(i));
        end
        iTRIGGER = 1'b0;
        tick();
        tick();

        // Trigger released while a write is stalled with two words buffered.
        wr_log.delete();
        iWAIT_REQUEST = 1'b1;
        start(25'h400, 25'd0);
        send(2, 16'hE000, 1'b0);
        chk("abort_pre_wr_en", oWR_EN, 1'b1);
        iTRIGGER = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("abort_hold_wr_en", oWR_EN, 1'b1);
            chk("abort_hold_addr", oWR_ADDR, 25'h400);
            chk("abort_hold_data", oWR_DATA, 16'hE000);
            chk("abort_hold_done", oDONE, 1'b0);
            tick();
        end
        iWAIT_REQUEST = 1'b0;
        tick();
        chk("abort_done", oDONE, 1'b1);
        chk("abort_flag", oABORTED, 1'b1);
        chk("abort_words", oWORDS_WRITTEN, 25'd1);
        chk("abort_wr_en", oWR_EN, 1'b0);
        tick();
        tick();
        check_log("abort_log", 1, 25'h400, 16'hE000);
        start(25'h480, 25'd0);
        chk("restart_aborted_clr", oABORTED, 1'b0);
        chk("restart_flushed", oWR_EN, 1'b0);
        chk("restart_rdy", oDATA_READY, 1'b1);
        chk("restart_words", oWORDS_WRITTEN, 25'd0);
        iTRIGGER = 1'b0;
        tick();
        tick();
        chk("reabort_flag", oABORTED, 1'b1);

        // Asynchronous reset in the middle of a stalled write.
        wr_log.delete();
        iWAIT_REQUEST = 1'b0;
        start(25'h500, 25'd0);
        send(1, 16'hF000, 1'b0);
        tick();
        iWAIT_REQUEST = 1'b1;
        send(1, 16'hF001, 1'b0);
        chk("arst_pre_wr_en", oWR_EN, 1'b1);
        chk("arst_pre_addr", oWR_ADDR, 25'h501);
        chk("arst_pre_words", oWORDS_WRITTEN, 25'd1);
        #2;
        iRST = 1'b1;
        #1;
        check_reset_outputs("arst");
        tick();
        iRST = 1'b0;
        iTRIGGER = 1'b0;
        iWAIT_REQUEST = 1'b0;
        tick();
        chk("arst_post_done", oDONE, 1'b1);
        chk("arst_post_wr_en", oWR_EN, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
